// File: rtl/archer_dmem_loader_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// archer_dmem_loader_ctrl_pkg
// Shared definitions for the Archer data-memory boot loader.
//   - XLEN / ADDRLEN defaults. When the core's own defines are already
//     present, those are used instead.
//   - ARCHER_CYCLE_LIMIT: the default RUN-cycle budget. It only matters when
//     ARCHER_CYCLE_LIMIT_EN is defined.
//   - ld_state_e: the loader FSM encoding. LD_HALT exists only with
//     ARCHER_CYCLE_LIMIT_EN.
//   - ld_word_addr(): the byte address of the idx-th loaded word. It wraps
//     modulo 2^ADDRLEN.
// -----------------------------------------------------------------------------
`ifndef XLEN
`define XLEN 32
`endif
`ifndef ADDRLEN
`define ADDRLEN 32
`endif
`ifndef ARCHER_CYCLE_LIMIT
`define ARCHER_CYCLE_LIMIT 5700
`endif

package archer_dmem_loader_ctrl_pkg;

   typedef enum logic [2:0] {
      LD_LOAD   = 3'd0,
      LD_SETTLE = 3'd1,
      LD_RUN    = 3'd2,
      LD_ERR    = 3'd3
`ifdef ARCHER_CYCLE_LIMIT_EN
      ,
      LD_HALT   = 3'd4
`endif
   } ld_state_e;

   function automatic logic [`ADDRLEN-1:0] ld_word_addr(input logic [`ADDRLEN-1:0] base,
                                                        input logic [`ADDRLEN-1:0] idx);
      return base + (idx << 2);
   endfunction

endpackage

// File: rtl/archer_dmem_loader_ctrl_if.sv
// -----------------------------------------------------------------------------
// archer_dmem_loader_ctrl_if
// This interface bundles three groups of signals around the loader:
//   - host : host image stream (host_valid/host_ready/host_data/host_last)
//   - core : the core's data-memory port (core_addr/core_datain/core_wen/
//            core_ben/core_dataout)
//   - mem  : the SRAM port (mem_addr/mem_datain/mem_wen/mem_ben/mem_dataout)
// Modports:
//   - slave  : the loader's view of the interface.
//   - master : the surroundings' view (host, core and SRAM).
// -----------------------------------------------------------------------------
interface archer_dmem_loader_ctrl_if;

   logic                host_valid;
   logic                host_ready;
   logic [`XLEN-1:0]    host_data;
   logic                host_last;

   logic [`ADDRLEN-1:0] core_addr;
   logic [`XLEN-1:0]    core_datain;
   logic                core_wen;
   logic [3:0]          core_ben;
   logic [`XLEN-1:0]    core_dataout;

   logic [`ADDRLEN-1:0] mem_addr;
   logic [`XLEN-1:0]    mem_datain;
   logic                mem_wen;
   logic [3:0]          mem_ben;
   logic [`XLEN-1:0]    mem_dataout;

   modport slave (
      input  host_valid, host_data, host_last,
      input  core_addr, core_datain, core_wen, core_ben,
      input  mem_dataout,
      output host_ready, core_dataout,
      output mem_addr, mem_datain, mem_wen, mem_ben
   );

   modport master (
      output host_valid, host_data, host_last,
      output core_addr, core_datain, core_wen, core_ben,
      output mem_dataout,
      input  host_ready, core_dataout,
      input  mem_addr, mem_datain, mem_wen, mem_ben
   );

endinterface

// File: rtl/archer_dmem_port_mux.sv
// -----------------------------------------------------------------------------
// archer_dmem_port_mux
// This is the combinational owner select for the data SRAM port.
//   - When core_own_i is 1, the core drives the SRAM directly.
//   - Otherwise the loader's write port drives it. The core's write enable is
//     then dropped, so the core cannot write outside RUN.
//   - Read data always passes straight back to the core.
// Ports:
//   core_own_i                          core owns the port (RUN)
//   ld_addr_i/ld_datain_i/ld_wen_i/ld_ben_i        loader write port
//   core_addr_i/core_datain_i/core_wen_i/core_ben_i core port
//   mem_addr_o/mem_datain_o/mem_wen_o/mem_ben_o     SRAM port
//   mem_dataout_i -> core_dataout_o                 read data return
// -----------------------------------------------------------------------------
module archer_dmem_port_mux (
   input  logic                core_own_i,
   input  logic [`ADDRLEN-1:0] ld_addr_i,
   input  logic [`XLEN-1:0]    ld_datain_i,
   input  logic                ld_wen_i,
   input  logic [3:0]          ld_ben_i,
   input  logic [`ADDRLEN-1:0] core_addr_i,
   input  logic [`XLEN-1:0]    core_datain_i,
   input  logic                core_wen_i,
   input  logic [3:0]          core_ben_i,
   input  logic [`XLEN-1:0]    mem_dataout_i,
   output logic [`ADDRLEN-1:0] mem_addr_o,
   output logic [`XLEN-1:0]    mem_datain_o,
   output logic                mem_wen_o,
   output logic [3:0]          mem_ben_o,
   output logic [`XLEN-1:0]    core_dataout_o
);

   assign mem_addr_o     = core_own_i ? core_addr_i   : ld_addr_i;
   assign mem_datain_o   = core_own_i ? core_datain_i : ld_datain_i;
   assign mem_wen_o      = core_own_i ? core_wen_i    : ld_wen_i;
   assign mem_ben_o      = core_own_i ? core_ben_i    : ld_ben_i;
   assign core_dataout_o = mem_dataout_i;

endmodule

// File: rtl/archer_dmem_loader_ctrl.sv
// -----------------------------------------------------------------------------
// archer_dmem_loader_ctrl
// Boot sequencer and data-memory port arbiter for the Archer RV32IM core.
// The block moves through these phases:
//   LOAD   : holds the core in reset. Host words are written straight into the
//            SRAM at LOAD_BASE + 4*load_count.
//   SETTLE : waits SETTLE_CYCLES cycles after the last word is written.
//   RUN    : core_rst_n is released and the core owns the SRAM port.
//   ERR    : an image longer than MAX_WORDS without host_last. The core stays
//            in reset.
//   HALT   : the RUN budget (CYCLE_LIMIT cycles) has expired. This phase
//            exists only when ARCHER_CYCLE_LIMIT_EN is defined.
// Ports:
//   clk, rst_n  - clock; synchronous active-low reset
//   bus         - archer_dmem_loader_ctrl_if.slave (host, core and mem groups)
//   core_rst_n  - reset to the core (active low, registered)
//   load_count  - number of words accepted
//   load_err    - sticky overflow flag
//   running     - high while in RUN
//   halted      - high in HALT (only with ARCHER_CYCLE_LIMIT_EN)
// Optional feature macro: ARCHER_CYCLE_LIMIT_EN
// -----------------------------------------------------------------------------
module archer_dmem_loader_ctrl
   import archer_dmem_loader_ctrl_pkg::*;
#(
   parameter logic [`ADDRLEN-1:0] LOAD_BASE     = '0,
   parameter int                  MAX_WORDS     = 1024,
   parameter int                  SETTLE_CYCLES = 2,
   parameter int                  CYCLE_LIMIT   = `ARCHER_CYCLE_LIMIT
) (
   input  logic                               clk,
   input  logic                               rst_n,
   archer_dmem_loader_ctrl_if.slave           bus,
   output logic                               core_rst_n,
   output logic [$clog2(MAX_WORDS+1)-1:0]     load_count,
   output logic                               load_err,
   output logic                               running
`ifdef ARCHER_CYCLE_LIMIT_EN
   ,
   output logic                               halted
`endif
);

   localparam int LCW = $clog2(MAX_WORDS+1);
   localparam logic [LCW-1:0] LAST_IDX = LCW'(MAX_WORDS-1);
   // A SETTLE_CYCLES of 0 still costs one cycle, because SETTLE is a real state.
   localparam int SCW = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES);
   localparam logic [SCW-1:0] SETTLE_LAST = (SETTLE_CYCLES < 1) ? '0 : SCW'(SETTLE_CYCLES-1);

   if (LOAD_BASE[1:0] != 2'b00) begin : g_bad_base
      $error("LOAD_BASE must be word-aligned");
   end
   if (MAX_WORDS < 1 || CYCLE_LIMIT < 1) begin : g_bad_size
      $error("MAX_WORDS and CYCLE_LIMIT must be at least 1");
   end

   ld_state_e        state_q, state_d;
   logic [LCW-1:0]   load_count_q, load_count_d;
   logic [SCW-1:0]   settle_cnt_q, settle_cnt_d;
   logic             host_ready_q, host_ready_d;
   logic             core_rst_n_q, core_rst_n_d;
   logic             load_err_q, load_err_d;
   logic             running_q, running_d;
   logic             accept;
   logic [`ADDRLEN-1:0] ld_addr;

`ifdef ARCHER_CYCLE_LIMIT_EN
   localparam int RCW = (CYCLE_LIMIT < 2) ? 1 : $clog2(CYCLE_LIMIT);
   localparam logic [RCW-1:0] RUN_LAST = RCW'(CYCLE_LIMIT-1);
   logic [RCW-1:0]   run_cnt_q, run_cnt_d;
   logic             halted_q, halted_d;
`endif

   // host_ready_q is only ever 1 in LOAD; the state term keeps that explicit.
   assign accept  = bus.host_valid && host_ready_q && (state_q == LD_LOAD);
   assign ld_addr = ld_word_addr(LOAD_BASE, `ADDRLEN'(load_count_q));

   always_comb begin
      state_d      = state_q;
      load_count_d = load_count_q;
      settle_cnt_d = '0;
`ifdef ARCHER_CYCLE_LIMIT_EN
      run_cnt_d    = '0;
`endif
      case (state_q)
         LD_LOAD: begin
            if (accept) begin
               load_count_d = load_count_q + 1'b1;
               // host_last wins over overflow: a full-length image is legal.
               if (bus.host_last)
                  state_d = LD_SETTLE;
               else if (load_count_q == LAST_IDX)
                  state_d = LD_ERR;
            end
         end
         LD_SETTLE: begin
            if (settle_cnt_q == SETTLE_LAST)
               state_d = LD_RUN;
            else
               settle_cnt_d = settle_cnt_q + 1'b1;
         end
         LD_RUN: begin
`ifdef ARCHER_CYCLE_LIMIT_EN
            run_cnt_d = run_cnt_q + 1'b1;
            if (run_cnt_q == RUN_LAST)
               state_d = LD_HALT;
`endif
         end
         default: state_d = state_q;
      endcase

      // The status outputs are registered from the next state, so they
      // change on the same edge as the state register.
      host_ready_d = (state_d == LD_LOAD);
      core_rst_n_d = (state_d == LD_RUN);
      running_d    = (state_d == LD_RUN);
      load_err_d   = load_err_q || (state_d == LD_ERR);
`ifdef ARCHER_CYCLE_LIMIT_EN
      halted_d     = (state_d == LD_HALT);
`endif
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= LD_LOAD;
         load_count_q <= '0;
         settle_cnt_q <= '0;
         host_ready_q <= 1'b0;
         core_rst_n_q <= 1'b0;
         load_err_q   <= 1'b0;
         running_q    <= 1'b0;
`ifdef ARCHER_CYCLE_LIMIT_EN
         run_cnt_q    <= '0;
         halted_q     <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         load_count_q <= load_count_d;
         settle_cnt_q <= settle_cnt_d;
         host_ready_q <= host_ready_d;
         core_rst_n_q <= core_rst_n_d;
         load_err_q   <= load_err_d;
         running_q    <= running_d;
`ifdef ARCHER_CYCLE_LIMIT_EN
         run_cnt_q    <= run_cnt_d;
         halted_q     <= halted_d;
`endif
      end
   end

   archer_dmem_port_mux u_port_mux (
      .core_own_i     (state_q == LD_RUN),
      .ld_addr_i      (ld_addr),
      .ld_datain_i    (bus.host_data),
      .ld_wen_i       (accept),
      .ld_ben_i       (accept ? 4'hF : 4'h0),
      .core_addr_i    (bus.core_addr),
      .core_datain_i  (bus.core_datain),
      .core_wen_i     (bus.core_wen),
      .core_ben_i     (bus.core_ben),
      .mem_dataout_i  (bus.mem_dataout),
      .mem_addr_o     (bus.mem_addr),
      .mem_datain_o   (bus.mem_datain),
      .mem_wen_o      (bus.mem_wen),
      .mem_ben_o      (bus.mem_ben),
      .core_dataout_o (bus.core_dataout)
   );

   assign bus.host_ready = host_ready_q;
   assign core_rst_n     = core_rst_n_q;
   assign load_count     = load_count_q;
   assign load_err       = load_err_q;
   assign running        = running_q;
`ifdef ARCHER_CYCLE_LIMIT_EN
   assign halted         = halted_q;
`endif

endmodule

// File: tb/tb_archer_dmem_loader_ctrl.sv
// -----------------------------------------------------------------------------
// tb_archer_dmem_loader_ctrl
// Directed bench for archer_dmem_loader_ctrl. The DUT is configured with
// LOAD_BASE=0x100, MAX_WORDS=4, SETTLE_CYCLES=2 and CYCLE_LIMIT=10.
// Inputs change 1 ns after a rising edge. Combinational outputs are sampled
// 1 ns after that.
// -----------------------------------------------------------------------------
module tb_archer_dmem_loader_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        core_rst_n;
   logic [2:0]  load_count;
   logic        load_err;
   logic        running;
`ifdef ARCHER_CYCLE_LIMIT_EN
   logic        halted;
`endif
   int n_cmp = 0;
   int n_bad = 0;

   archer_dmem_loader_ctrl_if bus ();

   archer_dmem_loader_ctrl #(
      .LOAD_BASE     (32'h100),
      .MAX_WORDS     (4),
      .SETTLE_CYCLES (2),
      .CYCLE_LIMIT   (10)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus),
      .core_rst_n (core_rst_n),
      .load_count (load_count),
      .load_err   (load_err),
      .running    (running)
`ifdef ARCHER_CYCLE_LIMIT_EN
      ,
      .halted     (halted)
`endif
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.host_valid  = 1'b0;
      bus.host_data   = '0;
      bus.host_last   = 1'b0;
      bus.core_addr   = '0;
      bus.core_datain = '0;
      bus.core_wen    = 1'b0;
      bus.core_ben    = 4'h0;
      bus.mem_dataout = '0;
   endtask

   // Applies one reset edge, then one release edge; host_ready is 1 on return.
   task automatic do_reset();
      idle_inputs();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_n = 1'b0;
      step();
      #1;
      n_cmp++; if (core_rst_n !== 1'b0) begin n_bad++; $display("FAIL rst_core_rst_n got %b exp 0", core_rst_n); end
      n_cmp++; if (bus.host_ready !== 1'b0) begin n_bad++; $display("FAIL rst_host_ready got %b exp 0", bus.host_ready); end
      n_cmp++; if (load_count !== 3'd0) begin n_bad++; $display("FAIL rst_load_count got %0d exp 0", load_count); end
      n_cmp++; if (load_err !== 1'b0) begin n_bad++; $display("FAIL rst_load_err got %b exp 0", load_err); end
      n_cmp++; if (running !== 1'b0) begin n_bad++; $display("FAIL rst_running got %b exp 0", running); end
      n_cmp++; if (bus.mem_wen !== 1'b0) begin n_bad++; $display("FAIL rst_mem_wen got %b exp 0", bus.mem_wen); end
`ifdef ARCHER_CYCLE_LIMIT_EN
      n_cmp++; if (halted !== 1'b0) begin n_bad++; $display("FAIL rst_halted got %b exp 0", halted); end
`endif
      rst_n = 1'b1;
      step();
      n_cmp++; if (bus.host_ready !== 1'b1) begin n_bad++; $display("FAIL rel_host_ready got %b exp 1", bus.host_ready); end
   endtask

   // Three back-to-back words, then the settle interval and RUN entry.
   task automatic test_load3();
      logic [31:0] w [3];
      w[0] = 32'h0000_0013; w[1] = 32'hDEAD_BEEF; w[2] = 32'h1234_5678;
      for (int i = 0; i < 3; i++) begin
         bus.host_valid = 1'b1;
         bus.host_data  = w[i];
         bus.host_last  = (i == 2);
         #1;
         n_cmp++; if (bus.mem_wen !== 1'b1 || bus.mem_ben !== 4'hF) begin n_bad++; $display("FAIL load3_wen[%0d] got wen=%b ben=%h exp 1/f", i, bus.mem_wen, bus.mem_ben); end
         n_cmp++; if (bus.mem_addr !== 32'h100 + 32'(4*i)) begin n_bad++; $display("FAIL load3_addr[%0d] got %h exp %h", i, bus.mem_addr, 32'h100 + 32'(4*i)); end
         n_cmp++; if (bus.mem_datain !== w[i]) begin n_bad++; $display("FAIL load3_data[%0d] got %h exp %h", i, bus.mem_datain, w[i]); end
         step();
      end
      bus.host_valid = 1'b0;
      bus.host_last  = 1'b0;
      n_cmp++; if (load_count !== 3'd3) begin n_bad++; $display("FAIL load3_count got %0d exp 3", load_count); end
      n_cmp++; if (bus.host_ready !== 1'b0) begin n_bad++; $display("FAIL load3_ready got %b exp 0", bus.host_ready); end
      // Settle cycle 1: a core write must not reach the SRAM.
      bus.core_wen = 1'b1;
      bus.core_ben = 4'hF;
      #1;
      n_cmp++; if (bus.mem_wen !== 1'b0) begin n_bad++; $display("FAIL settle_mask got %b exp 0", bus.mem_wen); end
      n_cmp++; if (core_rst_n !== 1'b0) begin n_bad++; $display("FAIL settle1_core_rst_n got %b exp 0", core_rst_n); end
      step();
      n_cmp++; if (core_rst_n !== 1'b0) begin n_bad++; $display("FAIL settle2_core_rst_n got %b exp 0", core_rst_n); end
      bus.core_wen = 1'b0;
      bus.core_ben = 4'h0;
      step();
      n_cmp++; if (core_rst_n !== 1'b1 || running !== 1'b1) begin n_bad++; $display("FAIL run_entry got rst_n=%b run=%b exp 1/1", core_rst_n, running); end
   endtask

   // Runs in RUN cycle 1, immediately after test_load3.
   task automatic test_run_mux();
      bus.core_addr   = 32'h200;
      bus.core_datain = 32'hCAFE_F00D;
      bus.core_wen    = 1'b1;
      bus.core_ben    = 4'h3;
      bus.mem_dataout = 32'hA5A5_0001;
      bus.host_valid  = 1'b1;
      #1;
      n_cmp++; if (bus.mem_addr !== 32'h200) begin n_bad++; $display("FAIL run_addr got %h exp 00000200", bus.mem_addr); end
      n_cmp++; if (bus.mem_datain !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL run_datain got %h exp cafef00d", bus.mem_datain); end
      n_cmp++; if (bus.mem_wen !== 1'b1 || bus.mem_ben !== 4'h3) begin n_bad++; $display("FAIL run_wen_ben got %b/%h exp 1/3", bus.mem_wen, bus.mem_ben); end
      n_cmp++; if (bus.core_dataout !== 32'hA5A5_0001) begin n_bad++; $display("FAIL run_dataout got %h exp a5a50001", bus.core_dataout); end
      n_cmp++; if (bus.host_ready !== 1'b0) begin n_bad++; $display("FAIL run_ready got %b exp 0", bus.host_ready); end
      step();
      n_cmp++; if (load_count !== 3'd3 || running !== 1'b1) begin n_bad++; $display("FAIL run_ignore_host got cnt=%0d run=%b exp 3/1", load_count, running); end
      idle_inputs();
   endtask

   task automatic test_mid_run_reset();
      rst_n = 1'b0;
      step();
      n_cmp++; if (core_rst_n !== 1'b0 || running !== 1'b0) begin n_bad++; $display("FAIL midrst_core got rst_n=%b run=%b exp 0/0", core_rst_n, running); end
      n_cmp++; if (load_count !== 3'd0) begin n_bad++; $display("FAIL midrst_count got %0d exp 0", load_count); end
      rst_n = 1'b1;
      step();
      n_cmp++; if (bus.host_ready !== 1'b1 || core_rst_n !== 1'b0) begin n_bad++; $display("FAIL midrst_load got ready=%b rst_n=%b exp 1/0", bus.host_ready, core_rst_n); end
   endtask

   task automatic test_gaps();
      logic [31:0] w [3];
      w[0] = 32'h0000_0013; w[1] = 32'hDEAD_BEEF; w[2] = 32'h1234_5678;
      do_reset();
      for (int i = 0; i < 6; i++) begin
         if (i % 2 == 0) begin
            bus.host_valid = 1'b1;
            bus.host_data  = w[i/2];
            bus.host_last  = (i == 4);
            #1;
            n_cmp++; if (bus.mem_wen !== 1'b1 || bus.mem_addr !== 32'h100 + 32'(2*i) || bus.mem_datain !== w[i/2]) begin
               n_bad++; $display("FAIL gap_write[%0d] got wen=%b addr=%h data=%h exp 1/%h/%h", i, bus.mem_wen, bus.mem_addr, bus.mem_datain, 32'h100 + 32'(2*i), w[i/2]); end
         end else begin
            bus.host_valid = 1'b0;
            bus.host_data  = 32'hFFFF_FFFF;
            bus.host_last  = 1'b0;
            #1;
            n_cmp++; if (bus.mem_wen !== 1'b0 || bus.mem_ben !== 4'h0) begin n_bad++; $display("FAIL gap_idle[%0d] got wen=%b ben=%h exp 0/0", i, bus.mem_wen, bus.mem_ben); end
         end
         step();
      end
      idle_inputs();
      n_cmp++; if (load_count !== 3'd3) begin n_bad++; $display("FAIL gap_count got %0d exp 3", load_count); end
      step();
      n_cmp++; if (core_rst_n !== 1'b1) begin n_bad++; $display("FAIL gap_release got %b exp 1", core_rst_n); end
   endtask

   task automatic test_overflow();
      do_reset();
      for (int i = 0; i < 4; i++) begin
         bus.host_valid = 1'b1;
         bus.host_data  = 32'h1000 + 32'(i);
         bus.host_last  = 1'b0;
         #1;
         n_cmp++; if (bus.mem_wen !== 1'b1 || bus.mem_addr !== 32'h100 + 32'(4*i)) begin n_bad++; $display("FAIL ovf_write[%0d] got wen=%b addr=%h exp 1/%h", i, bus.mem_wen, bus.mem_addr, 32'h100 + 32'(4*i)); end
         step();
      end
      n_cmp++; if (load_err !== 1'b1) begin n_bad++; $display("FAIL ovf_err got %b exp 1", load_err); end
      n_cmp++; if (load_count !== 3'd4) begin n_bad++; $display("FAIL ovf_count got %0d exp 4", load_count); end
      n_cmp++; if (bus.host_ready !== 1'b0 || core_rst_n !== 1'b0) begin n_bad++; $display("FAIL ovf_hold got ready=%b rst_n=%b exp 0/0", bus.host_ready, core_rst_n); end
      bus.core_wen = 1'b1;
      #1;
      n_cmp++; if (bus.mem_wen !== 1'b0) begin n_bad++; $display("FAIL ovf_mem_wen got %b exp 0", bus.mem_wen); end
      repeat (3) step();
      n_cmp++; if (load_count !== 3'd4 || load_err !== 1'b1 || core_rst_n !== 1'b0 || running !== 1'b0) begin
         n_bad++; $display("FAIL ovf_sticky got cnt=%0d err=%b rst_n=%b run=%b exp 4/1/0/0", load_count, load_err, core_rst_n, running); end
      idle_inputs();
   endtask

   // A full MAX_WORDS image that ends with host_last is not an overflow.
   task automatic test_boundary_last();
      do_reset();
      for (int i = 0; i < 4; i++) begin
         bus.host_valid = 1'b1;
         bus.host_data  = 32'h2000 + 32'(i);
         bus.host_last  = (i == 3);
         step();
      end
      idle_inputs();
      n_cmp++; if (load_err !== 1'b0 || load_count !== 3'd4) begin n_bad++; $display("FAIL full_last got err=%b cnt=%0d exp 0/4", load_err, load_count); end
      step();
      n_cmp++; if (core_rst_n !== 1'b0) begin n_bad++; $display("FAIL full_settle got %b exp 0", core_rst_n); end
      step();
      n_cmp++; if (core_rst_n !== 1'b1) begin n_bad++; $display("FAIL full_release got %b exp 1", core_rst_n); end
   endtask

   task automatic test_cycle_limit();
      bit found = 1'b0;
      do_reset();
      bus.host_valid = 1'b1;
      bus.host_data  = 32'h0000_0013;
      bus.host_last  = 1'b1;
      step();
      idle_inputs();
      for (int k = 0; k < 8 && !found; k++) begin
         step();
         if (running === 1'b1) found = 1'b1;
      end
      n_cmp++; if (found !== 1'b1) begin n_bad++; $display("FAIL lim_enter_run got %b exp 1", found); end
      repeat (9) step();
      n_cmp++; if (running !== 1'b1 || core_rst_n !== 1'b1) begin n_bad++; $display("FAIL lim_cycle10 got run=%b rst_n=%b exp 1/1", running, core_rst_n); end
      step();
`ifdef ARCHER_CYCLE_LIMIT_EN
      n_cmp++; if (halted !== 1'b1 || core_rst_n !== 1'b0 || running !== 1'b0) begin
         n_bad++; $display("FAIL lim_halt got halted=%b rst_n=%b run=%b exp 1/0/0", halted, core_rst_n, running); end
      bus.core_wen = 1'b1;
      #1;
      n_cmp++; if (bus.mem_wen !== 1'b0) begin n_bad++; $display("FAIL lim_halt_wen got %b exp 0", bus.mem_wen); end
      bus.core_wen = 1'b0;
`else
      n_cmp++; if (running !== 1'b1 || core_rst_n !== 1'b1) begin n_bad++; $display("FAIL lim_cycle11 got run=%b rst_n=%b exp 1/1", running, core_rst_n); end
      repeat (5) step();
      n_cmp++; if (running !== 1'b1) begin n_bad++; $display("FAIL lim_unbounded got %b exp 1", running); end
`endif
   endtask

   initial begin
      rst_n = 1'b0;
      idle_inputs();
      test_reset();
      test_load3();
      test_run_mux();
      test_mid_run_reset();
      test_gaps();
      test_overflow();
      test_boundary_last();
      test_cycle_limit();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout exp completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/archer_dmem_loader_ctrl.md
Name: archer_dmem_loader_ctrl

Overview:
- Boot sequencer and data-memory port arbiter between the host/bench and the Archer RV32IM single-cycle core.
- After reset it holds the core in reset and streams a host-supplied word image into the data SRAM.
- It then waits a fixed settle interval and releases the core.
- From then on it hands the SRAM port to the core unchanged.

Parameters:
- LOAD_BASE, 0, byte address of the first loaded word; must be word-aligned.
- MAX_WORDS, 1024, maximum image length in words.
- SETTLE_CYCLES, 2, cycles the core stays in reset after the last word is written.
- CYCLE_LIMIT, 5700, RUN-state cycle budget; used only with the optional feature.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- host_valid  in  1  host word available.
- host_ready  out  1  loader accepts a word this cycle.
- host_data  in  `XLEN  image word.
- host_last  in  1  marks the final image word; qualified by host_valid.
- core_rst_n  out  1  reset to the core; active low.
- core_addr  in  `ADDRLEN  core dmem address.
- core_datain  in  `XLEN  core store data.
- core_wen  in  1  core write enable.
- core_ben  in  4  core byte enables.
- core_dataout  out  `XLEN  load data to the core.
- mem_addr  out  `ADDRLEN  SRAM address.
- mem_datain  out  `XLEN  SRAM write data.
- mem_wen  out  1  SRAM write enable.
- mem_ben  out  4  SRAM byte enables.
- mem_dataout  in  `XLEN  SRAM read data.
- load_count  out  clog2(MAX_WORDS+1)  number of words accepted.
- load_err  out  1  overflow error flag; sticky until reset.
- running  out  1  high while in RUN.

Behaviour:
- States: LOAD, SETTLE, RUN, ERR, plus HALT (feature only). State register, core_rst_n, host_ready, load_count, load_err and running are all registered.
- Reset values (rst_n=0 at an edge): state=LOAD, core_rst_n=0, host_ready=0, load_count=0, load_err=0, running=0, settle counter=0.
- rst_n low in any state, including mid-load or mid-run, returns the block to LOAD with these values.
- LOAD:
  - host_ready=1 from the first cycle after reset release.
  - A word is accepted when host_valid && host_ready.
  - In the same cycle the block drives mem_addr=LOAD_BASE+4*load_count, mem_datain=host_data, mem_wen=1, mem_ben=4'hF. The SRAM writes at that edge, so write latency is 0 cycles.
  - load_count increments on each accepted word.
  - When no word is accepted: mem_wen=0 and mem_ben=0.
- LOAD transitions:
  - Accepted word with host_last=1: go to SETTLE; host_ready=0 next cycle.
  - Accepted word without host_last while load_count==MAX_WORDS-1: the word is written, then go to ERR.
  - Otherwise stay in LOAD.
- SETTLE:
  - Counts SETTLE_CYCLES cycles.
  - mem_wen=0; loader owns the port.
  - core_rst_n stays 0.
  - At terminal count go to RUN, with core_rst_n=1 and running=1 from the next cycle.
- RUN:
  - mem_* = core_* combinationally.
  - core_dataout = mem_dataout in every state.
  - host_ready=0; host_valid is ignored.
  - RUN is terminal until reset.
- ERR: load_err=1, core_rst_n=0, host_ready=0, mem_wen=0. Terminal until reset.
- Arbitration: the core never owns the port outside RUN. core_wen is masked to 0 in every state except RUN.
- Widths and wrap: LOAD_BASE+4*load_count is computed at `ADDRLEN bits and wraps modulo 2^ADDRLEN. load_count never exceeds MAX_WORDS.

Optional Feature:
- Macro: ARCHER_CYCLE_LIMIT_EN.
- Enabled:
  - A RUN-cycle counter clears on entry to RUN and increments each RUN cycle.
  - When it reaches CYCLE_LIMIT, go to HALT: core_rst_n=0, running=0, mem_wen=0.
  - Extra output halted (1 bit) is 1 in HALT and resets to 0. HALT is terminal until reset.
- Disabled: no counter, no HALT state, no halted port; RUN is unbounded.

Decomposition:
- Package / archerdefs additions:
  - State encoding constants LD_LOAD=0, LD_SETTLE=1, LD_RUN=2, LD_ERR=3, LD_HALT=4 (3-bit).
  - Macro default for ARCHER_CYCLE_LIMIT.
- XLEN and ADDRLEN are reused from the existing defines.
- One natural sub-module: archer_dmem_port_mux, the combinational owner-select between loader and core. The FSM and counters stay in the top.

Test Plan:
- Reset, then 3 words 0x00000013, 0xDEADBEEF, 0x12345678 (last on the third), host_valid held high, LOAD_BASE=0x100 -> writes at 0x100/0x104/0x108 with ben=F on consecutive cycles; load_count=3; core_rst_n rises exactly 2 cycles after the last write; running=1.
- Host with valid gaps (valid on alternate cycles) -> no write in gap cycles; same addresses written.
- MAX_WORDS=4, 4 words without host_last -> 4 writes, then load_err=1; core_rst_n stays 0; later host_valid is ignored.
- In RUN, core_wen=1, core_addr=0x200, ben=4'h3 -> mem_* mirrors the core the same cycle. In SETTLE, core_wen=1 -> mem_wen=0.
- rst_n low for 1 cycle mid-RUN -> core_rst_n=0, load_count=0, state LOAD, host_ready=1 the next cycle.
- ARCHER_CYCLE_LIMIT_EN with CYCLE_LIMIT=10 -> halted=1 and core_rst_n=0 after exactly 10 RUN cycles; without the macro, running stays 1 past 10 cycles.
